// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - Shared widths, opcodes, FSM encodings and command layout for the ALU sequencer.
package alu_seq_pkg;

  localparam int DATA_W   = 8;
  localparam int RES_W    = 16;
  localparam int CMD_W    = 3 * DATA_W;
  localparam int SETTLE_W = 4;

  localparam logic [DATA_W-1:0] OP_0         = 8'd0;
  localparam logic [DATA_W-1:0] OP_1         = 8'd1;
  localparam logic [DATA_W-1:0] OP_2         = 8'd2;
  localparam logic [DATA_W-1:0] OP_3         = 8'd3;
  localparam logic [DATA_W-1:0] OP_4         = 8'd4;
  localparam logic [DATA_W-1:0] OP_MAX_LEGAL = OP_4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] control;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data1;
  } cmd_t;

  function automatic logic is_legal_op(input logic [DATA_W-1:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - Power-of-two command FIFO; a push while full is dropped, never passed through.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [CMD_W-1:0]              push_data,
  input  logic                          pop,
  output logic [CMD_W-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Queues ALU commands, drives one at a time to the ALU and returns its result.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data1,
  input  logic [DATA_W-1:0] cmd_data2,
  input  logic [DATA_W-1:0] cmd_control,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] control,
  output logic              alu_reset,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_error,
  output logic [RES_W-1:0]  op_count
);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   data1_q, data1_d, data2_q, data2_d, control_q, control_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d, op_count_q, op_count_d;
  logic                alu_reset_q;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  logic [CMD_W-1:0]    fifo_pop_data;
  cmd_t                head;

  assign cmd_ready = !reset && (fifo_count < FCNT_W'(FIFO_DEPTH));
  assign fifo_push = cmd_valid && cmd_ready;
  assign head      = cmd_t'(fifo_pop_data);

  alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cmd_control, cmd_data2, cmd_data1}),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assert property (@(posedge clk) disable iff (reset) fifo_full |-> !cmd_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    control_d    = control_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    op_count_d   = op_count_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_legal_op(head.control)) begin
            data1_d   = head.data1;
            data2_d   = head.data2;
            control_d = head.control;
            cnt_d     = SETTLE_W'(SETTLE_CYCLES);
            state_d   = ST_SETTLE;
          end else begin
            // Illegal opcodes never reach the ALU; its inputs keep the last legal command.
            rsp_result_d = '0;
            rsp_error_d  = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - SETTLE_W'(1);
        if (cnt_q == SETTLE_W'(1)) begin
          rsp_result_d = alu_result;
          rsp_error_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + RES_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      control_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      control_q    <= control_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      op_count_q   <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    alu_reset_q <= reset;
  end

  assign data1      = data1_q;
  assign data2      = data2_q;
  assign control    = control_q;
  assign alu_reset  = alu_reset_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign op_count   = op_count_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles the ALU operands are held before the result is sampled (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  upstream command present.
REQ-006 SHALL have port cmd_ready  out  1  queue can accept a command.
REQ-007 SHALL have ports cmd_data1, cmd_data2, cmd_control  in  8 each  operands and opcode of the command.
REQ-008 SHALL have ports data1, data2, control  out  8 each  operands and opcode driven to the 8-bit ALU.
REQ-009 SHALL have port alu_reset  out  1  reset driven to the ALU.
REQ-010 SHALL have port alu_result  in  16  ALU result, combinational from data1/data2/control.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  downstream accepts response.
REQ-013 SHALL have ports rsp_result  out  16  and rsp_error  out  1  captured result and illegal-opcode flag.
REQ-014 SHALL have port op_count  out  16  number of completed response handshakes.

Function
REQ-015 Command accepted on an edge where cmd_valid and cmd_ready are both high; cmd_ready = (queue occupancy < FIFO_DEPTH), no same-cycle pass-through when full.
REQ-016 Queue is FIFO-ordered; simultaneous push and pop with occupancy between 1 and FIFO_DEPTH-1 leaves occupancy unchanged.
REQ-017 FSM states: IDLE, SETTLE, RESP.
REQ-018 IDLE: if queue non-empty, pop head; legal opcode (0..4) -> load data1/data2/control, load settle counter with SETTLE_CYCLES, go SETTLE; illegal opcode -> leave ALU outputs unchanged, set rsp_result=0, rsp_error=1, go RESP.
REQ-019 SETTLE: decrement counter each cycle; on the edge where counter reaches 0, capture alu_result into rsp_result, rsp_error=0, go RESP.
REQ-020 RESP: rsp_valid=1; rsp_result/rsp_error stable while rsp_valid high and rsp_ready low; on rsp_valid&rsp_ready go IDLE, clear rsp_valid next cycle.
REQ-021 One command in flight; next pop occurs no earlier than the cycle after the response handshake.
REQ-022 Latency, command accepted into empty queue at edge N with rsp_ready held high: operands change after edge N+1, rsp_valid high after edge N+1+SETTLE_CYCLES.
REQ-023 data1/data2/control SHALL hold their last legal values between commands.
REQ-024 op_count increments by 1 on every response handshake, including errors; wraps 16'hFFFF -> 16'h0000.
REQ-025 cmd_valid while queue full: command not accepted; upstream holds it.

Reset
REQ-026 While reset is high at an edge: state IDLE, queue emptied, data1/data2/control=0, rsp_valid=0, rsp_result=0, rsp_error=0, op_count=0, settle counter=0.
REQ-027 alu_reset SHALL be a registered copy of reset: 1 during reset and the cycle after reset deasserts, otherwise 0.
REQ-028 Reset mid-operation (SETTLE or RESP) discards the in-flight command and all queued commands; no response is produced for them.
REQ-029 cmd_ready is 0 while reset is high.

Structure
REQ-030 Package alu_seq_pkg SHALL hold opcode constants OP_0..OP_4 (8'd0..8'd4), OP_MAX_LEGAL, FSM state encodings and the 8/16-bit width constants.
REQ-031 The queue SHALL be a sub-module alu_cmd_fifo (24-bit entries, parameter FIFO_DEPTH, push/pop/full/empty/count).

Verification
REQ-032 Reset held 3 cycles, then released -> all outputs 0, alu_reset high one extra cycle, cmd_ready=1.
REQ-033 Commands (F1,08,op0..op4) back-to-back, rsp_ready=1 -> control steps 0,1,2,3,4 in order, five responses each matching ALU model, op_count=5.
REQ-034 Command (F1,08,op 8'd7) -> rsp_valid with rsp_error=1, rsp_result=0, data1/data2/control unchanged.
REQ-035 rsp_ready=0, push 6 commands with FIFO_DEPTH=4 -> cmd_ready low after 5 accepted (4 queued + 1 in RESP); rsp_result stable; releasing rsp_ready drains all in order.
REQ-036 Reset asserted during SETTLE with 2 queued -> no rsp_valid afterwards, queue empty, op_count=0.
REQ-037 Preload op_count to 16'hFFFF via 65535 handshakes (or force) then one more -> op_count=16'h0000.
